tx_frame_ctrl: RTL and testbench
================================

Name: tx_frame_ctrl

Overview:
Frame-level sequencer for the OFDM transmit chain. On a frame request it programs the configuration register block over the CFG bus: mode word, then an optional 4096-bit allocation vector, then a vector-load strobe. It then gates the source-side symbol handshake into the modulator for exactly N accepted words. Finally it waits for the chain output to go idle and pulses DONE_O.

Parameters:
ALLOC_WORDS, 128, number of 32-bit words in the allocation vector (4096/32)
NW_W, 16, width of the frame word counter
DRAIN_IDLE, 8, consecutive cycles OUT_CYC_I must be low before the frame counts as drained
TO_CYC, 255, CFG ACK watchdog limit in cycles (used only with CFG_TIMEOUT_EN)

Ports:
CLK_I  in  1  system clock
RST_I  in  1  asynchronous, active-low reset (0 = reset)
REQ_I  in  1  frame request pulse; sampled only in IDLE
REQ_STD_I  in  2  standard select for the frame
REQ_MOD_I  in  2  modulation select for the frame
REQ_NWORDS_I  in  NW_W  number of payload words to pass
REQ_VEC_I  in  1  1 = reload the allocation vector
VEC_DAT_I  in  32  allocation vector word
VEC_RDY_I  in  1  VEC_DAT_I valid
VEC_RD_O  out  1  vector word consumed this cycle
CFG_DAT_O  out  32  config write data
CFG_ADR_O  out  2  config address
CFG_WE_O  out  1  config write enable
CFG_STB_O  out  1  config strobe
CFG_ACK_I  in  1  config acknowledge
SRC_CYC_I  in  1  payload source cycle
SRC_STB_I  in  1  payload source strobe
SRC_ACK_O  out  1  acknowledge to payload source
TX_CYC_O  out  1  gated cycle to modulator
TX_STB_O  out  1  gated strobe to modulator
TX_ACK_I  in  1  modulator acknowledge
OUT_CYC_I  in  1  chain output CYC (from output stage)
BUSY_O  out  1  frame in progress
DONE_O  out  1  one-cycle frame-complete pulse
ERR_O  out  1  one-cycle abort pulse (CFG_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- CFG address map (fixed):
  - ADR 0: mode word, bits[1:0]=STD, [3:2]=MOD, rest 0.
  - ADR 1: allocation vector word stream; the register block auto-increments internally.
  - ADR 2: write of 1 issues the vector-load (VEC_LD) strobe.
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE -> CFG_MODE -> (CFG_VEC -> CFG_LD if REQ_VEC_I latched) -> DATA -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On REQ_I=1, latch STD, MOD, NWORDS and VEC; BUSY_O=1 from the next cycle.
  - REQ_I is ignored in all other states.
- CFG writes:
  - CFG_STB_O, CFG_WE_O, CFG_ADR_O and CFG_DAT_O are registered and held until the cycle CFG_ACK_I=1.
  - STB drops the cycle after ACK. At most one write is outstanding.
- CFG_VEC:
  - A word is fetched only when VEC_RDY_I=1. VEC_RD_O pulses the cycle the word is loaded into CFG_DAT_O.
  - VEC_RDY_I low stalls with STB=0.
  - Exactly ALLOC_WORDS writes, then go to CFG_LD.
- DATA:
  - TX_CYC_O=SRC_CYC_I, TX_STB_O=SRC_STB_I, SRC_ACK_O=TX_ACK_I, all combinational and only while count<NWORDS.
  - Count increments on TX_STB_O & TX_ACK_I.
  - When count reaches NWORDS, TX_CYC_O and TX_STB_O are forced to 0 in the same cycle the count updates, and the state goes to DRAIN.
  - NWORDS=0: skip DATA and go directly to DRAIN.
  - Outside DATA: TX_* = 0 and SRC_ACK_O = 0.
- DRAIN:
  - Idle counter increments while OUT_CYC_I=0 and clears on OUT_CYC_I=1.
  - On reaching DRAIN_IDLE, go to DONE.
- DONE: DONE_O=1 for one cycle, BUSY_O drops the same cycle, then IDLE.
- Reset asserted mid-frame: immediate return to IDLE, all strobes 0, no DONE_O.
- Counter wrap: the word counter is NW_W bits and compares with equality. NWORDS=2^NW_W-1 is legal.

Optional Feature:
- Macro CFG_TIMEOUT_EN.
- When defined:
  - An 8-bit-plus watchdog counts cycles with CFG_STB_O=1 and CFG_ACK_I=0.
  - When the count reaches TO_CYC: drop STB, pulse ERR_O for one cycle, go to IDLE with BUSY_O=0, no DONE_O.
  - The watchdog clears on every ACK.
- When undefined: the block waits indefinitely for ACK and ERR_O is constant 0.

Decomposition:
- Shared package: state encoding, CFG address constants (ADR_MODE=0, ADR_VEC=1, ADR_LD=2), mode-word field positions.
- One natural sub-module, tx_cfg_writer: the single-outstanding CFG write engine (req/addr/data in, done out, watchdog under CFG_TIMEOUT_EN).

Test Plan:
- Reset with CFG_ACK_I tied 1 -> all outputs 0; REQ_I STD=1 MOD=2 NWORDS=4 VEC=0 -> one CFG write ADR0 DAT=0x9, then DATA; 4 handshakes pass; DONE_O once after OUT_CYC_I low 8 cycles.
- VEC=1 with VEC_RDY_I toggling every other cycle -> exactly 128 ADR1 writes in VEC_DAT_I order, 128 VEC_RD_O pulses, then ADR2 DAT=1 before DATA.
- NWORDS=3, source offers 5 words -> SRC_ACK_O for exactly 3; TX_STB_O=0 from the cycle the 3rd ACK completes.
- NWORDS=0 -> no TX_STB_O activity; DONE_O after drain; REQ_I pulsed while BUSY_O=1 is ignored.
- RST_I low during CFG_VEC at word 50 -> CFG_STB_O=0 immediately, IDLE, no DONE_O; next request completes normally.
- CFG_TIMEOUT_EN, CFG_ACK_I held 0 -> ERR_O pulse after 255 cycles of STB, BUSY_O=0, no DONE_O.

Source files
------------

// File: rtl/tx_frame_ctrl_pkg.sv
// Shared types and constants for the OFDM transmit frame sequencer:
// FSM state encoding, CFG register map and mode-word field layout.
package tx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_MODE,
    S_CFG_VEC,
    S_CFG_LD,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] ADR_MODE = 2'd0;
  localparam logic [1:0] ADR_VEC  = 2'd1;
  localparam logic [1:0] ADR_LD   = 2'd2;

  localparam int MODE_STD_LSB = 0;
  localparam int MODE_MOD_LSB = 2;

  localparam logic [31:0] LD_CMD = 32'd1;

  function automatic logic [31:0] mode_word(input logic [1:0] std, input logic [1:0] modu);
    logic [31:0] w;
    w = '0;
    w[MODE_STD_LSB +: 2] = std;
    w[MODE_MOD_LSB +: 2] = modu;
    return w;
  endfunction

endpackage

// File: rtl/tx_cfg_writer.sv
// Single-outstanding CFG bus write engine: registers addr/data on req, holds
// STB until ACK. With `define CFG_TIMEOUT_EN an ACK watchdog aborts the write.
module tx_cfg_writer
`ifdef CFG_TIMEOUT_EN
#(
  parameter int TO_CYC = 255
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [1:0]  adr,
  input  logic [31:0] dat,
  output logic [31:0] cfg_dat,
  output logic [1:0]  cfg_adr,
  output logic        cfg_we,
  output logic        cfg_stb,
  input  logic        cfg_ack,
  output logic        done,
  output logic        timeout
);

  // done is the ACK cycle itself; STB falls on the following edge.
  assign done = cfg_stb & cfg_ack;

`ifdef CFG_TIMEOUT_EN
  localparam int WD_W = $clog2(TO_CYC) + 1;

  logic [WD_W-1:0] wd_cnt;

  // wd_cnt holds the number of earlier unacknowledged STB cycles.
  assign timeout = cfg_stb & ~cfg_ack & (wd_cnt == WD_W'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!cfg_stb || cfg_ack || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_stb <= 1'b0;
      cfg_we  <= 1'b0;
      cfg_adr <= '0;
      cfg_dat <= '0;
    end else if (cfg_stb) begin
      if (done || timeout) begin
        cfg_stb <= 1'b0;
        cfg_we  <= 1'b0;
        cfg_adr <= '0;
        cfg_dat <= '0;
      end
    end else if (req) begin
      cfg_stb <= 1'b1;
      cfg_we  <= 1'b1;
      cfg_adr <= adr;
      cfg_dat <= dat;
    end
  end

endmodule

// File: rtl/tx_frame_ctrl.sv
// Frame sequencer: programs mode / allocation vector / VEC_LD over CFG, passes
// NWORDS payload words, then waits for output drain. Option: `define CFG_TIMEOUT_EN.
module tx_frame_ctrl
  import tx_frame_ctrl_pkg::*;
#(
  parameter int ALLOC_WORDS = 128,
  parameter int NW_W        = 16,
`ifdef CFG_TIMEOUT_EN
  parameter int TO_CYC      = 255,
`endif
  parameter int DRAIN_IDLE  = 8
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            REQ_I,
  input  logic [1:0]      REQ_STD_I,
  input  logic [1:0]      REQ_MOD_I,
  input  logic [NW_W-1:0] REQ_NWORDS_I,
  input  logic            REQ_VEC_I,
  input  logic [31:0]     VEC_DAT_I,
  input  logic            VEC_RDY_I,
  output logic            VEC_RD_O,
  output logic [31:0]     CFG_DAT_O,
  output logic [1:0]      CFG_ADR_O,
  output logic            CFG_WE_O,
  output logic            CFG_STB_O,
  input  logic            CFG_ACK_I,
  input  logic            SRC_CYC_I,
  input  logic            SRC_STB_I,
  output logic            SRC_ACK_O,
  output logic            TX_CYC_O,
  output logic            TX_STB_O,
  input  logic            TX_ACK_I,
  input  logic            OUT_CYC_I,
  output logic            BUSY_O,
  output logic            DONE_O,
  output logic            ERR_O
);

  localparam int VC_W = $clog2(ALLOC_WORDS + 1);
  localparam int ID_W = $clog2(DRAIN_IDLE + 1);

  state_t            state, state_nx;
  logic [1:0]        std_q, mod_q;
  logic [NW_W-1:0]   nwords_q, word_cnt;
  logic              vec_q;
  logic [VC_W-1:0]   vec_cnt;
  logic [ID_W-1:0]   idle_cnt;

  logic              wr_req, wr_done, wr_timeout;
  logic [1:0]        wr_adr;
  logic [31:0]       wr_dat;
  logic              in_data, tx_fire;
  state_t            payload_nx;

  // Handshakes: a word transfers on a cycle with STB & ACK both high (CFG, SRC/TX);
  // VEC_RDY_I is the vector word valid and VEC_RD_O the consume strobe of that cycle.
  assign in_data    = (state == S_DATA);
  assign TX_CYC_O   = in_data & SRC_CYC_I;
  assign TX_STB_O   = in_data & SRC_STB_I;
  assign SRC_ACK_O  = in_data & TX_ACK_I;
  assign tx_fire    = TX_STB_O & TX_ACK_I;
  assign VEC_RD_O   = (state == S_CFG_VEC) & wr_req;
  assign BUSY_O     = (state != S_IDLE) && (state != S_DONE);
  assign DONE_O     = (state == S_DONE);
  assign payload_nx = (nwords_q == '0) ? S_DRAIN : S_DATA;

  always_comb begin
    state_nx = state;
    wr_req   = 1'b0;
    wr_adr   = ADR_MODE;
    wr_dat   = '0;
    case (state)
      S_IDLE: begin
        if (REQ_I) state_nx = S_CFG_MODE;
      end
      S_CFG_MODE: begin
        wr_req = ~CFG_STB_O;
        wr_adr = ADR_MODE;
        wr_dat = mode_word(std_q, mod_q);
        if (wr_done) state_nx = vec_q ? S_CFG_VEC : payload_nx;
      end
      S_CFG_VEC: begin
        wr_req = ~CFG_STB_O & VEC_RDY_I;
        wr_adr = ADR_VEC;
        wr_dat = VEC_DAT_I;
        if (wr_done && vec_cnt == VC_W'(ALLOC_WORDS - 1)) state_nx = S_CFG_LD;
      end
      S_CFG_LD: begin
        wr_req = ~CFG_STB_O;
        wr_adr = ADR_LD;
        wr_dat = LD_CMD;
        if (wr_done) state_nx = payload_nx;
      end
      S_DATA: begin
        if (tx_fire && (word_cnt + NW_W'(1)) == nwords_q) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!OUT_CYC_I && idle_cnt == ID_W'(DRAIN_IDLE - 1)) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (wr_timeout) state_nx = S_IDLE;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      std_q    <= '0;
      mod_q    <= '0;
      nwords_q <= '0;
      vec_q    <= 1'b0;
      vec_cnt  <= '0;
      word_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      if (state == S_IDLE && REQ_I) begin
        std_q    <= REQ_STD_I;
        mod_q    <= REQ_MOD_I;
        nwords_q <= REQ_NWORDS_I;
        vec_q    <= REQ_VEC_I;
      end
      if (state != S_CFG_VEC) vec_cnt <= '0;
      else if (wr_done)       vec_cnt <= vec_cnt + VC_W'(1);
      if (state != S_DATA)    word_cnt <= '0;
      else if (tx_fire)       word_cnt <= word_cnt + NW_W'(1);
      if (state != S_DRAIN || OUT_CYC_I) idle_cnt <= '0;
      else                               idle_cnt <= idle_cnt + ID_W'(1);
    end
  end

`ifdef CFG_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) err_q <= 1'b0;
    else        err_q <= wr_timeout;
  end

  assign ERR_O = err_q;
`else
  assign ERR_O = 1'b0;
`endif

  tx_cfg_writer
`ifdef CFG_TIMEOUT_EN
  #(.TO_CYC(TO_CYC))
`endif
  u_cfg_writer (
    .clk     (CLK_I),
    .rst_n   (RST_I),
    .req     (wr_req),
    .adr     (wr_adr),
    .dat     (wr_dat),
    .cfg_dat (CFG_DAT_O),
    .cfg_adr (CFG_ADR_O),
    .cfg_we  (CFG_WE_O),
    .cfg_stb (CFG_STB_O),
    .cfg_ack (CFG_ACK_I),
    .done    (wr_done),
    .timeout (wr_timeout)
  );

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl: requests push expected CFG writes, payload
// words and DONE/ERR events; a negedge monitor pops and compares them.
module tb_tx_frame_ctrl;
  import tx_frame_ctrl_pkg::*;

  localparam int NW_W        = 16;
  localparam int ALLOC_WORDS = 128;
  localparam int DRAIN_IDLE  = 8;
  localparam int TO_CYC      = 255;
  localparam int W           = 40;
  localparam logic [3:0] K_CFG  = 4'd0;
  localparam logic [3:0] K_TX   = 4'd1;
  localparam logic [3:0] K_DONE = 4'd2;
  localparam logic [3:0] K_ERR  = 4'd3;

  logic            CLK_I, RST_I, REQ_I, REQ_VEC_I;
  logic [1:0]      REQ_STD_I, REQ_MOD_I;
  logic [NW_W-1:0] REQ_NWORDS_I;
  logic [31:0]     VEC_DAT_I;
  logic            VEC_RDY_I, VEC_RD_O;
  logic [31:0]     CFG_DAT_O;
  logic [1:0]      CFG_ADR_O;
  logic            CFG_WE_O, CFG_STB_O, CFG_ACK_I;
  logic            SRC_CYC_I, SRC_STB_I, SRC_ACK_O;
  logic            TX_CYC_O, TX_STB_O, TX_ACK_I;
  logic            OUT_CYC_I, BUSY_O, DONE_O, ERR_O;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int tx_quota   = 0;
  int vec_idx    = 0;
  int vec_rd_cnt = 0;
  int low_run    = 0;
  int stb_run    = 0;
  int src_budget = 0;
  int src_sent   = 0;
  logic [7:0] ack_pat = 8'b1011_0111;

  tx_frame_ctrl dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .REQ_I(REQ_I), .REQ_STD_I(REQ_STD_I),
    .REQ_MOD_I(REQ_MOD_I), .REQ_NWORDS_I(REQ_NWORDS_I), .REQ_VEC_I(REQ_VEC_I),
    .VEC_DAT_I(VEC_DAT_I), .VEC_RDY_I(VEC_RDY_I), .VEC_RD_O(VEC_RD_O),
    .CFG_DAT_O(CFG_DAT_O), .CFG_ADR_O(CFG_ADR_O), .CFG_WE_O(CFG_WE_O),
    .CFG_STB_O(CFG_STB_O), .CFG_ACK_I(CFG_ACK_I), .SRC_CYC_I(SRC_CYC_I),
    .SRC_STB_I(SRC_STB_I), .SRC_ACK_O(SRC_ACK_O), .TX_CYC_O(TX_CYC_O),
    .TX_STB_O(TX_STB_O), .TX_ACK_I(TX_ACK_I), .OUT_CYC_I(OUT_CYC_I),
    .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ERR_O(ERR_O)
  );

  // clock / reset block
  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish earlier");
    $fatal(1, "bench stopped");
  end

  function automatic logic [W-1:0] mk(input logic [3:0] k, input logic we,
                                      input logic [1:0] adr, input logic [31:0] dat);
    return {k, 1'b0, we, adr, dat};
  endfunction

  function automatic logic [31:0] vec_word(input int k);
    return {16'hC0DE, 16'(k * 7 + 1)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic expect_evt(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got unexpected event %h, required none", name, act);
    end else begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge CLK_I);
      if (!RST_I) begin
        low_run = 0;
        stb_run = 0;
      end else begin
        if (CFG_STB_O && CFG_ACK_I) begin
          expect_evt("cfg_write", mk(K_CFG, CFG_WE_O, CFG_ADR_O, CFG_DAT_O));
          if (CFG_ADR_O == ADR_LD) check("vec_rd_count", 40'(vec_rd_cnt), 40'(ALLOC_WORDS));
        end
        if (VEC_RD_O) begin
          vec_rd_cnt++;
          vec_idx++;
          check("vec_rd_with_rdy", 40'(VEC_RDY_I), 40'd1);
        end
        if ((SRC_STB_I && SRC_ACK_O) || (TX_STB_O && TX_ACK_I))
          check("src_tx_pair", 40'(SRC_STB_I & SRC_ACK_O), 40'(TX_STB_O & TX_ACK_I));
        if (SRC_STB_I && SRC_ACK_O) src_sent++;
        if (TX_STB_O && TX_ACK_I) begin
          expect_evt("tx_word", mk(K_TX, 1'b0, 2'd0, 32'd0));
          if (tx_quota > 0) tx_quota--;
        end else if (tx_quota == 0 && SRC_STB_I) begin
          check("tx_stb_gated", 40'(TX_STB_O), 40'd0);
        end
        if (DONE_O) begin
          expect_evt("done", mk(K_DONE, 1'b0, 2'd0, 32'd0));
          check("done_drain_run", 40'(low_run), 40'(DRAIN_IDLE));
          check("busy_at_done", 40'(BUSY_O), 40'd0);
        end
        if (ERR_O) begin
          expect_evt("err", mk(K_ERR, 1'b0, 2'd0, 32'd0));
          check("err_stb_cycles", 40'(stb_run), 40'(TO_CYC));
          check("busy_at_err", 40'(BUSY_O), 40'd0);
        end
        low_run = OUT_CYC_I ? 0 : low_run + 1;
        stb_run = (CFG_STB_O && !CFG_ACK_I) ? stb_run + 1 : 0;
      end
    end
  end

  // payload source driver
  initial begin
    SRC_CYC_I = 1'b0;
    SRC_STB_I = 1'b0;
    TX_ACK_I  = 1'b0;
    forever begin
      @(posedge CLK_I);
      #1;
      SRC_CYC_I = (src_sent < src_budget);
      SRC_STB_I = SRC_CYC_I;
      TX_ACK_I  = ack_pat[0];
      ack_pat   = {ack_pat[0], ack_pat[7:1]};
    end
  end

  // allocation vector source, valid toggles every cycle
  initial begin
    VEC_RDY_I = 1'b0;
    VEC_DAT_I = '0;
    forever begin
      @(posedge CLK_I);
      #1;
      VEC_RDY_I = ~VEC_RDY_I;
      VEC_DAT_I = vec_word(vec_idx);
    end
  end

  task automatic request(input logic [1:0] std, input logic [1:0] modu, input logic [31:0] mode_exp,
                         input int n, input logic vec, input int offer, input bit want_err);
    check("idle_before_req", 40'(BUSY_O), 40'd0);
    REQ_I = 1'b1;
    REQ_STD_I = std;
    REQ_MOD_I = modu;
    REQ_NWORDS_I = NW_W'(n);
    REQ_VEC_I = vec;
    OUT_CYC_I = 1'b1;
    vec_idx = 0;
    vec_rd_cnt = 0;
    src_sent = 0;
    src_budget = offer;
    if (want_err) begin
      tx_quota = 0;
      exp_q.push_back(mk(K_ERR, 1'b0, 2'd0, 32'd0));
    end else begin
      tx_quota = n;
      exp_q.push_back(mk(K_CFG, 1'b1, 2'd0, mode_exp));
      if (vec) begin
        for (int k = 0; k < ALLOC_WORDS; k++) exp_q.push_back(mk(K_CFG, 1'b1, 2'd1, vec_word(k)));
        exp_q.push_back(mk(K_CFG, 1'b1, 2'd2, 32'd1));
      end
      for (int k = 0; k < n; k++) exp_q.push_back(mk(K_TX, 1'b0, 2'd0, 32'd0));
      exp_q.push_back(mk(K_DONE, 1'b0, 2'd0, 32'd0));
    end
    tick(1);
    REQ_I = 1'b0;
    check("busy_after_req", 40'(BUSY_O), 40'd1);
  endtask

  task automatic finish_frame(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 1 && exp_q[0][39:36] == K_DONE && tx_quota == 0) && n < 5000) begin
      tick(1);
      n++;
    end
    check({name, "_reach_drain"}, 40'(n < 5000), 40'd1);
    if (n >= 5000) begin
      exp_q.delete();
      tx_quota = 0;
      return;
    end
    tick(2);
    OUT_CYC_I = 1'b0;
    tick(3);
    OUT_CYC_I = 1'b1;
    tick(1);
    OUT_CYC_I = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick(1);
      n++;
    end
    check({name, "_done_seen"}, 40'(exp_q.size()), 40'd0);
    tick(2);
  endtask

  initial begin
    int n;
    RST_I = 1'b0;
    REQ_I = 1'b0;
    REQ_STD_I = '0;
    REQ_MOD_I = '0;
    REQ_NWORDS_I = '0;
    REQ_VEC_I = 1'b0;
    CFG_ACK_I = 1'b1;
    OUT_CYC_I = 1'b0;
    tick(3);
    check("rst_cfg_dat", 40'(CFG_DAT_O), 40'd0);
    check("rst_cfg_adr", 40'(CFG_ADR_O), 40'd0);
    check("rst_cfg_we", 40'(CFG_WE_O), 40'd0);
    check("rst_cfg_stb", 40'(CFG_STB_O), 40'd0);
    check("rst_vec_rd", 40'(VEC_RD_O), 40'd0);
    check("rst_src_ack", 40'(SRC_ACK_O), 40'd0);
    check("rst_tx_cyc", 40'(TX_CYC_O), 40'd0);
    check("rst_tx_stb", 40'(TX_STB_O), 40'd0);
    check("rst_busy", 40'(BUSY_O), 40'd0);
    check("rst_done", 40'(DONE_O), 40'd0);
    check("rst_err", 40'(ERR_O), 40'd0);
    RST_I = 1'b1;
    tick(2);

    request(2'd1, 2'd2, 32'h9, 4, 1'b0, 4, 1'b0);
    finish_frame("basic");

    request(2'd2, 2'd1, 32'h6, 6, 1'b1, 6, 1'b0);
    finish_frame("vector");

    request(2'd3, 2'd3, 32'hF, 3, 1'b0, 5, 1'b0);
    finish_frame("limit3");

    request(2'd0, 2'd1, 32'h4, 0, 1'b0, 2, 1'b0);
    REQ_I = 1'b1;
    REQ_NWORDS_I = 16'd7;
    tick(1);
    REQ_I = 1'b0;
    check("busy_ignores_req", 40'(BUSY_O), 40'd1);
    finish_frame("zero_words");
    tick(10);

    request(2'd1, 2'd1, 32'h5, 2, 1'b1, 2, 1'b0);
    n = 0;
    while (vec_rd_cnt < 50 && n < 1000) begin
      tick(1);
      n++;
    end
    check("reach_word50", 40'(vec_rd_cnt), 40'd50);
    RST_I = 1'b0;
    #1;
    check("midrst_cfg_stb", 40'(CFG_STB_O), 40'd0);
    check("midrst_busy", 40'(BUSY_O), 40'd0);
    check("midrst_vec_rd", 40'(VEC_RD_O), 40'd0);
    check("midrst_done", 40'(DONE_O), 40'd0);
    exp_q.delete();
    tx_quota = 0;
    src_budget = 0;
    OUT_CYC_I = 1'b0;
    tick(4);
    RST_I = 1'b1;
    tick(20);
    request(2'd3, 2'd0, 32'h3, 5, 1'b0, 5, 1'b0);
    finish_frame("after_reset");

    request(2'd2, 2'd3, 32'hE, 1, 1'b0, 3, 1'b0);
    finish_frame("one_word");

`ifdef CFG_TIMEOUT_EN
    CFG_ACK_I = 1'b0;
    request(2'd1, 2'd0, 32'h1, 2, 1'b0, 0, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    check("timeout_err_seen", 40'(exp_q.size()), 40'd0);
    CFG_ACK_I = 1'b1;
    tick(5);
    check("timeout_idle", 40'(BUSY_O), 40'd0);
`endif

    tick(10);
    check("queue_drained", 40'(exp_q.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
